// File: rtl/seg_display_scanner.sv
// Multiplexed N-digit common-anode seven-segment driver.
// A value is taken through a load/busy handshake and turned into BCD by a
// sequential double-dabble converter. The digits are then committed to the
// display registers in one cycle and scanned continuously onto the display.
module seg_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int WIDTH        = 13,
    parameter int SIGNED       = 1,
    parameter int BLANK_LZ     = 1,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  num,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg
);

    localparam int ND   = DIGITS - SIGNED;                // numeric digit positions
    localparam int NBCD = (WIDTH * 30103) / 100000 + 1;   // BCD digits for 2^WIDTH-1
    localparam int NE   = (ND > NBCD) ? ND : NBCD;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int IW   = $clog2(DIGITS);
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               state_r, state_next_s;
    logic                 accept_s, shift_s, commit_s;
    logic [WIDTH-1:0]     mag_s, bin_r;
    logic                 neg_s, neg_r;
    logic [4*NBCD-1:0]    bcd_r, bcd_adj_s;
    logic [4*NE-1:0]      bcd_ext_s;
    logic [CW-1:0]        cnt_r;
    logic                 busy_r, done_r, ovf_s, seen_s;
    logic [3:0]           dig_s;
    logic [6:0]           disp_r      [DIGITS];
    logic [6:0]           disp_next_s [DIGITS];
    logic [REFRESH_BITS-1:0] presc_r;
    logic [IW-1:0]        idx_r;
    logic [DIGITS-1:0]    anode_next_s, anode_r;
    logic [6:0]           seg_r;

    // Active-low abcdefg pattern of one decimal digit; anything else is blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        shift_s      = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == CW'(WIDTH - 1)) state_next_s = ST_COMMIT;
                else                         state_next_s = ST_SHIFT;
            end
            ST_COMMIT: begin
                commit_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sign and magnitude of the incoming value; the most negative number
    // negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        neg_s = 1'b0;
        mag_s = num;
        if (SIGNED != 0) begin
            neg_s = num[WIDTH-1];
            if (num[WIDTH-1]) mag_s = -num;
            else              mag_s = num;
        end else begin
            neg_s = 1'b0;
        end
    end

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int k = 0; k < NBCD; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
            else                         bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4];
        end
    end

    // Converter datapath: capture on accept, one add-3-and-shift step per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
            neg_r <= 1'b0;
        end else if (accept_s) begin
            bin_r <= mag_s;
            bcd_r <= '0;
            cnt_r <= '0;
            neg_r <= neg_s;
        end else if (shift_s) begin
            {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1'b1;
            cnt_r          <= cnt_r + CW'(1);
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
            neg_r <= neg_r;
        end
    end

    // Display image built from the finished BCD result: overflow, sign and zero blanking.
    always_comb begin
        bcd_ext_s                = '0;
        bcd_ext_s[4*NBCD-1:0]    = bcd_r;
        ovf_s                    = 1'b0;
        seen_s                   = 1'b0;
        dig_s                    = 4'd0;
        for (int i = 0; i < DIGITS; i++) disp_next_s[i] = SEG_BLANK;
        for (int k = ND; k < NE; k++) begin
            if (bcd_ext_s[4*k +: 4] != 4'd0) ovf_s = 1'b1;
            else                             ovf_s = ovf_s;
        end
        // Walk from the most significant numeric digit down so the blanking
        // flag turns off at the first non-zero digit (or at the ones digit).
        for (int j = ND - 1; j >= 0; j--) begin
            dig_s = bcd_ext_s[4*j +: 4];
            if (dig_s != 4'd0 || j == 0) seen_s = 1'b1;
            else                         seen_s = seen_s;
            if (BLANK_LZ != 0 && !seen_s) disp_next_s[DIGITS-1-j] = SEG_BLANK;
            else                          disp_next_s[DIGITS-1-j] = seg_code(dig_s);
        end
        if (SIGNED != 0) disp_next_s[0] = neg_r ? SEG_DASH : SEG_BLANK;
        else             disp_next_s[0] = disp_next_s[0];
        if (ovf_s) begin
            for (int i = 0; i < DIGITS; i++) disp_next_s[i] = SEG_DASH;
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Display registers, handshake flags: all digits change together in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) disp_r[i] <= SEG_BLANK;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (commit_s) begin
                for (int i = 0; i < DIGITS; i++) disp_r[i] <= disp_next_s[i];
            end else begin
                for (int i = 0; i < DIGITS; i++) disp_r[i] <= disp_r[i];
            end
            if (accept_s)      busy_r <= 1'b1;
            else if (commit_s) busy_r <= 1'b0;
            else               busy_r <= busy_r;
            done_r <= commit_s;
        end
    end

    // Refresh prescaler and digit index; index wraps at DIGITS-1 for any digit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else begin
            presc_r <= presc_r + REFRESH_BITS'(1);
            if (presc_r == {REFRESH_BITS{1'b1}}) begin
                if (idx_r == IW'(DIGITS - 1)) idx_r <= '0;
                else                          idx_r <= idx_r + IW'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // One-hot-low anode for the current index; index 0 is the leftmost (MSB) anode.
    always_comb begin
        anode_next_s = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IW'(i)) anode_next_s[DIGITS-1-i] = 1'b0;
            else                 anode_next_s[DIGITS-1-i] = 1'b1;
        end
    end

    // Registered scan outputs so anode and segments switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_r <= {DIGITS{1'b1}};
            seg_r   <= SEG_BLANK;
        end else begin
            anode_r <= anode_next_s;
            seg_r   <= disp_r[idx_r];
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign anode = anode_r;
    assign seg   = seg_r;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: four instances with different
// digit counts, widths, sign and blanking modes share one load/num stimulus.
module tb_seg_display_scanner;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100, S7 = 7'b0001111, S9 = 7'b0000100;
    localparam logic [6:0] SD = 7'b1111110, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n, load;
    logic [15:0] num16;
    logic        busy_a, busy_b, busy_c, busy_d, done_a, done_b, done_c, done_d;
    logic [3:0]  anode_a, anode_b;
    logic [5:0]  anode_c;
    logic [4:0]  anode_d;
    logic [6:0]  seg_a, seg_b, seg_c, seg_d;

    int checks = 0;
    int errors = 0;

    int dig_c [4] = '{4, 4, 6, 5};
    int wid_c [4] = '{13, 13, 16, 13};
    int sgn_c [4] = '{1, 1, 0, 1};
    int blk_c [4] = '{1, 0, 1, 1};
    int done_at [4] = '{14, 14, 17, 14};

    logic [7:0] an_pad [4];
    logic [6:0] seg_w  [4];
    logic       done_w [4];
    logic       busy_w [4];

    logic [6:0] cap [4][8];
    bit         got_m [4][8];
    int         onehot_bad [4];
    int         order_bad  [4];
    bit         wrapped    [4];

    typedef struct {
        logic [15:0] num;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    seg_display_scanner #(.DIGITS(4), .WIDTH(13), .SIGNED(1), .BLANK_LZ(1), .REFRESH_BITS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .num(num16[12:0]), .load(load),
        .busy(busy_a), .done(done_a), .anode(anode_a), .seg(seg_a));
    seg_display_scanner #(.DIGITS(4), .WIDTH(13), .SIGNED(1), .BLANK_LZ(0), .REFRESH_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .num(num16[12:0]), .load(load),
        .busy(busy_b), .done(done_b), .anode(anode_b), .seg(seg_b));
    seg_display_scanner #(.DIGITS(6), .WIDTH(16), .SIGNED(0), .BLANK_LZ(1), .REFRESH_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .num(num16), .load(load),
        .busy(busy_c), .done(done_c), .anode(anode_c), .seg(seg_c));
    seg_display_scanner #(.DIGITS(5), .WIDTH(13), .SIGNED(1), .BLANK_LZ(1), .REFRESH_BITS(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .num(num16[12:0]), .load(load),
        .busy(busy_d), .done(done_d), .anode(anode_d), .seg(seg_d));

    // Gather the four instances into arrays so checks can loop over them.
    always_comb begin
        an_pad[0] = {4'hF, anode_a};  an_pad[1] = {4'hF, anode_b};
        an_pad[2] = {2'b11, anode_c}; an_pad[3] = {3'b111, anode_d};
        seg_w[0] = seg_a;  seg_w[1] = seg_b;  seg_w[2] = seg_c;  seg_w[3] = seg_d;
        done_w[0] = done_a; done_w[1] = done_b; done_w[2] = done_c; done_w[3] = done_d;
        busy_w[0] = busy_a; busy_w[1] = busy_b; busy_w[2] = busy_c; busy_w[3] = busy_d;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'b0000001;  1: enc = 7'b1001111;  2: enc = 7'b0010010;
            3: enc = 7'b0000110;  4: enc = 7'b1001100;  5: enc = 7'b0100100;
            6: enc = 7'b0100000;  7: enc = 7'b0001111;  8: enc = 7'b0000000;
            9: enc = 7'b0000100;  default: enc = SB;
        endcase
    endfunction

    // Reference display: plain decimal arithmetic on the numeric value.
    // Digit i (0 = leftmost) lives at bits [55-7*i -: 7].
    function automatic logic [55:0] model(input int digits, input int width, input int sgn,
                                          input int blk, input logic [15:0] v);
        longint val, lim, p;
        bit neg;
        int nd;
        logic [55:0] r;
        r   = {8{SB}};
        val = longint'(v) & ((longint'(1) << width) - 1);
        neg = 1'b0;
        if (sgn != 0 && val >= (longint'(1) << (width - 1))) begin
            neg = 1'b1;
            val = (longint'(1) << width) - val;
        end
        nd  = digits - sgn;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        if (val >= lim) begin
            for (int i = 0; i < digits; i++) r[55-7*i -: 7] = SD;
        end else begin
            p = 1;
            for (int j = 0; j < nd; j++) begin
                if (blk == 0 || j == 0 || val >= p)
                    r[55-7*(digits-1-j) -: 7] = enc(int'((val / p) % 10));
                p = p * 10;
            end
            if (sgn != 0 && neg) r[55 -: 7] = SD;
        end
        return r;
    endfunction

    function automatic int dec_pos(input logic [7:0] an, input int digits);
        int pos = -1;
        int cnt = 0;
        for (int b = 0; b < digits; b++) begin
            if (an[b] == 1'b0) begin
                cnt++;
                pos = digits - 1 - b;
            end
        end
        if (cnt != 1) pos = -1;
        return pos;
    endfunction

    // Watch the scan for a fixed window and record what each digit position shows.
    task automatic capture();
        int p;
        int prev [4];
        for (int d = 0; d < 4; d++) begin
            prev[d] = -1; onehot_bad[d] = 0; order_bad[d] = 0; wrapped[d] = 1'b0;
            for (int i = 0; i < 8; i++) got_m[d][i] = 1'b0;
        end
        repeat (48) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                p = dec_pos(an_pad[d], dig_c[d]);
                if (p < 0) onehot_bad[d]++;
                else begin
                    cap[d][p]   = seg_w[d];
                    got_m[d][p] = 1'b1;
                    if (prev[d] >= 0 && p != prev[d]) begin
                        if (p != (prev[d] + 1) % dig_c[d]) order_bad[d]++;
                        if (p == 0) wrapped[d] = 1'b1;
                    end
                    prev[d] = p;
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("onehot_dut%0d", d), 64'(onehot_bad[d]), 64'd0);
            chk($sformatf("scan_order_dut%0d", d), 64'(order_bad[d]), 64'd0);
            chk($sformatf("scan_wrap_dut%0d", d), 64'(wrapped[d]), 64'd1);
        end
    endtask

    task automatic check_model(input logic [15:0] v, input int first_d);
        logic [55:0] e;
        for (int d = first_d; d < 4; d++) begin
            e = model(dig_c[d], wid_c[d], sgn_c[d], blk_c[d], v);
            for (int i = 0; i < dig_c[d]; i++)
                chk($sformatf("disp_dut%0d_num%0h_dig%0d", d, v, i),
                    {56'd0, got_m[d][i], cap[d][i]}, {56'd0, 1'b1, e[55-7*i -: 7]});
        end
    endtask

    task automatic check_blank();
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < dig_c[d]; i++)
                chk($sformatf("blank_dut%0d_dig%0d", d, i), {56'd0, got_m[d][i], cap[d][i]},
                    {56'd0, 1'b1, SB});
    endtask

    // One load pulse (optionally followed by ignored loads with another value),
    // then timing of busy and done on every instance.
    task automatic run_load(input logic [15:0] v, input bit spam, input logic [15:0] other);
        int dn [4];
        int dc [4];
        for (int d = 0; d < 4; d++) begin dn[d] = -1; dc[d] = 0; end
        @(negedge clk);
        num16 = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (spam) num16 = other;
        for (int d = 0; d < 4; d++) chk($sformatf("busy_after_load_dut%0d", d), 64'(busy_w[d]), 64'd1);
        for (int n = 1; n <= 20; n++) begin
            load = spam && n >= 3 && n <= 10;
            @(negedge clk);
            if (n == 13) chk("busy_mid_a", 64'(busy_a), 64'd1);
            if (n == 14) chk("busy_end_a", 64'(busy_a), 64'd0);
            for (int d = 0; d < 4; d++)
                if (done_w[d]) begin dc[d]++; dn[d] = n; end
        end
        load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("done_count_dut%0d", d), 64'(dc[d]), 64'd1);
            chk($sformatf("done_edge_dut%0d", d), 64'(dn[d]), 64'(done_at[d]));
        end
    endtask

    initial begin
        logic [15:0] v;
        int dcount;
        tbl[0] = '{16'h1E37, {SD, S4, S5, S7}};
        tbl[1] = '{16'd5,    {SB, SB, SB, S5}};
        tbl[2] = '{16'd0,    {SB, SB, SB, S0}};
        tbl[3] = '{16'd999,  {SB, S9, S9, S9}};
        tbl[4] = '{16'd1000, {SD, SD, SD, SD}};
        tbl[5] = '{16'h1000, {SD, SD, SD, SD}};
        tbl[6] = '{16'h1C19, {SD, S9, S9, S9}};
        tbl[7] = '{16'd40,   {SB, SB, S4, S0}};
        tbl[8] = '{16'hFFFF, {SD, SB, SB, S1}};
        tbl[9] = '{16'd100,  {SB, S1, S0, S0}};

        rst_n = 1'b0; load = 1'b0; num16 = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_anode_a", 64'(anode_a), 64'hF);
        chk("rst_seg_a",   64'(seg_a),   64'h7F);
        chk("rst_busy_a",  64'(busy_a),  64'd0);
        chk("rst_done_a",  64'(done_a),  64'd0);
        chk("rst_anode_c", 64'(anode_c), 64'h3F);
        rst_n = 1'b1;
        #1;
        chk("post_rst_anode_a", 64'(anode_a), 64'hF);
        @(negedge clk);
        chk("first_scan_anode_a", 64'(anode_a), 64'h7);
        chk("first_scan_seg_a",   64'(seg_a),   64'h7F);
        capture();
        check_blank();

        // Table vectors: hand-written expectations for instance A, model for the rest.
        for (int t = 0; t < 10; t++) begin
            run_load(tbl[t].num, 1'b0, 16'd0);
            capture();
            for (int i = 0; i < 4; i++)
                chk($sformatf("tbl%0d_a_dig%0d", t, i), {56'd0, got_m[0][i], cap[0][i]},
                    {56'd0, 1'b1, tbl[t].exp[27-7*i -: 7]});
            check_model(tbl[t].num, 1);
        end

        // Loads repeated during a conversion are dropped; the first value is shown.
        run_load(16'd291, 1'b1, 16'd999);
        capture();
        check_model(16'd291, 0);

        // Reset in the middle of a conversion aborts it with no commit.
        @(negedge clk);
        num16 = 16'd321;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_anode_a", 64'(anode_a), 64'hF);
        chk("midrst_seg_a",   64'(seg_a),   64'h7F);
        chk("midrst_busy_a",  64'(busy_a),  64'd0);
        chk("midrst_done_a",  64'(done_a),  64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_a || done_c) dcount++;
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        capture();
        check_blank();

        // Randomised values against the reference model.
        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 2))
                0:       v = 16'($urandom);
                1:       v = 16'($urandom_range(0, 1100));
                default: v = 16'(32'h2000 - $urandom_range(1, 1100));
            endcase
            run_load(v, 1'b0, 16'd0);
            capture();
            check_model(v, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Parametrised multiplexed N-digit seven-segment driver with a built-in sequential binary-to-BCD converter (double-dabble). It accepts a value through a load/busy handshake and converts it over multiple cycles. It then commits the digits atomically and continuously scans them onto a common-anode display. It adds signed/unsigned modes, leading-zero blanking, overflow indication and configurable refresh rate over the earlier fixed 4-digit driver.

Parameters:
DIGITS, 4, number of display digits (2..8); leftmost digit is index 0.
WIDTH, 13, bit width of num input (4..27).
SIGNED, 1, 1: num is two's complement, leftmost digit reserved for sign; 0: unsigned, all digits numeric.
BLANK_LZ, 1, 1: leading zeros are blanked (ones digit always shown); 0: zeros shown.
REFRESH_BITS, 18, each digit is driven for 2^REFRESH_BITS clk cycles.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
num  input  WIDTH  value to display, sampled on accepted load.
load  input  1  request conversion of num.
busy  output  1  high while conversion in progress; load ignored when high.
done  output  1  one-cycle pulse on the cycle the new digits are committed.
anode  output  DIGITS  active-low digit enables; anode[DIGITS-1] = leftmost digit.
seg  output  7  active-low segments {a,b,c,d,e,f,g}, a = MSB.

Behaviour:
- Reset (rst_n low, async): busy=0, done=0, anode=all 1, seg=7'b1111111, prescaler=0, digit index=0, all display registers = blank, FSM=IDLE. Reset mid-conversion aborts it; no commit.
- FSM IDLE: load=1 on an edge samples num. In signed mode, mag = |num|; -2^(WIDTH-1) yields 2^(WIDTH-1), held unsigned in WIDTH bits. neg = num[WIDTH-1] when SIGNED, else 0. Go to SHIFT; busy=1 from the next cycle.
- SHIFT: exactly WIDTH cycles of add-3-then-shift over a BCD register wide enough for 2^WIDTH-1; then go to COMMIT.
- COMMIT (1 cycle): build display registers, pulse done=1, busy=0, go to IDLE. Total: load edge to commit edge = WIDTH+1 clocks. A load in IDLE is accepted on the clock after done.
- Load while busy is ignored and not queued. num changes after acceptance have no effect.
- Numeric digits: ND = DIGITS-SIGNED. Overflow if mag > 10^ND - 1; then every digit (sign included) shows '-'.
- Sign digit (SIGNED=1): '-' if neg, else blank. Negative zero cannot occur.
- Leading-zero blanking: when BLANK_LZ=1, numeric zeros left of the most significant non-zero digit are blank. The ones digit always shows, so 0 displays '0'.
- Scan: prescaler counts 0..2^REFRESH_BITS-1 and wraps. On wrap, digit index increments mod DIGITS, wrapping DIGITS-1 to 0 even for non-power-of-two DIGITS. Index i drives anode bit DIGITS-1-i low and all other anode bits high. seg is the encoding of display register i.
- Scan runs independently of conversion. Display registers change only in COMMIT, so no partial values are ever shown.
- anode and seg are registered: they update one clock after the index changes and never glitch between digits.
- Encoding (active-low abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, '-'=1111110, blank=1111111.

Test Plan:
- Reset with REFRESH_BITS=2: during and after reset, anode=4'b1111, seg=7'b1111111 until first scan update; busy=0. Afterwards all digits show blank.
- Defaults, num=13'h1E37 (-457), load for 1 cycle -> busy high 13+ cycles, done pulse 14 edges after load. Scan then gives anode 0111/seg 1111110, 1011/1001100, 1101/0100100, 1110/0001111.
- num=5 -> digits blank,blank,blank,'5'. Rebuild with BLANK_LZ=0 -> blank,'0','0','5'. num=0 with BLANK_LZ=1 -> only ones digit shows 0000001.
- Overflow: num=999 shows " 999"; num=1000 and num=13'h1000 (-4096) each show "----" (all seg 1111110); num=-999 shows "-999".
- Load asserted again on cycles 3..10 of a conversion -> ignored, single done pulse, first value displayed. rst_n low at cycle 6 of a conversion -> outputs return to reset values, no done.
- DIGITS=6, WIDTH=16, SIGNED=0, num=65535 -> " 65535" (BLANK_LZ=1). Anode steps 011111 to 111110 then wraps to 011111. With DIGITS=5, index wraps 4 to 0.
